// File: rtl/audio_src_fade_switch.sv
// audio_src_fade_switch: click-free NUM_SRC-way PCM source selector with linear fade-out/fade-in
module audio_src_fade_switch #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W = 16,
  parameter int RAMP_SHIFT = 6,
  localparam int SEL_W = $clog2(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic                      in_valid,
  input  logic [SEL_W-1:0]          sel,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_valid,
  output logic [SEL_W-1:0]          active_sel,
  output logic                      busy
);
  localparam int PW = DATA_W + RAMP_SHIFT + 1;
  localparam logic [RAMP_SHIFT:0] FULL = {1'b1, {RAMP_SHIFT{1'b0}}};
  typedef enum logic [1:0] {PLAY, FADE_OUT, FADE_IN} state_t;
  state_t state, state_n;
  logic [RAMP_SHIFT:0] g, g_n;
  logic [SEL_W-1:0] tgt, tgt_n, act_n;
  logic signed [DATA_W-1:0] s;
  logic signed [PW-1:0] s_ext, g_ext;
  logic sel_ok, req;
  assign busy = state != PLAY;
  always_comb begin
    s = src_data[active_sel*DATA_W +: DATA_W];
    s_ext = {{(RAMP_SHIFT+1){s[DATA_W-1]}}, s};
    g_ext = {{DATA_W{1'b0}}, g};
    sel_ok = 32'(sel) < NUM_SRC;
    req = sel_ok && sel != active_sel;
    state_n = state;
    g_n = g;
    tgt_n = tgt;
    act_n = active_sel;
    case (state)
      PLAY: begin
        if (req) begin
          state_n = FADE_OUT;
          tgt_n = sel;
          g_n = g - 1'b1;
        end
      end
      FADE_OUT: begin
        tgt_n = req ? sel : tgt;
        // a request for the still-routed source reverses the ramp in place
        if (sel_ok && sel == active_sel) begin
          state_n = FADE_IN;
          g_n = g + 1'b1;
        end else if (g == '0) begin
          act_n = tgt_n;
          state_n = FADE_IN;
          g_n = 1;
        end else g_n = g - 1'b1;
      end
      FADE_IN: begin
        if (req) begin
          tgt_n = sel;
          // already silent: switch on the spot instead of fading below zero
          if (g == '0) begin
            act_n = sel;
            g_n = 1;
          end else begin
            state_n = FADE_OUT;
            g_n = g - 1'b1;
          end
        end else if (g == FULL) state_n = PLAY;
        else g_n = g + 1'b1;
      end
      default: state_n = FADE_IN;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FADE_IN;
      g <= '0;
      tgt <= '0;
      active_sel <= '0;
      out_data <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= DATA_W'((s_ext * g_ext) >>> RAMP_SHIFT);
        state <= state_n;
        g <= g_n;
        tgt <= tgt_n;
        active_sel <= act_n;
      end
    end
  end
endmodule

// File: tb/tb_audio_src_fade_switch.sv
// tb_audio_src_fade_switch: vector table plus scoreboard for the fade switch (FULL=4)
module tb_audio_src_fade_switch;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic [63:0] src_data = '0;
  logic in_valid = 0;
  logic [1:0] sel = 0;
  logic signed [15:0] out_data;
  logic out_valid, busy;
  logic [1:0] active_sel;
  logic [47:0] src3_data = '0;
  logic in_valid3 = 0;
  logic [1:0] sel3 = 0;
  logic signed [15:0] out_data3;
  logic out_valid3, busy3;
  logic [1:0] active_sel3;
  audio_src_fade_switch #(.NUM_SRC(4), .DATA_W(16), .RAMP_SHIFT(2)) dut (
    .clk(clk), .rst(rst), .src_data(src_data), .in_valid(in_valid), .sel(sel),
    .out_data(out_data), .out_valid(out_valid), .active_sel(active_sel), .busy(busy));
  audio_src_fade_switch #(.NUM_SRC(3), .DATA_W(16), .RAMP_SHIFT(2)) dut3 (
    .clk(clk), .rst(rst), .src_data(src3_data), .in_valid(in_valid3), .sel(sel3),
    .out_data(out_data3), .out_valid(out_valid3), .active_sel(active_sel3), .busy(busy3));
  typedef struct {int d; int a; bit b; int n;} exp_t;
  typedef struct {logic [1:0] sel; int d; int a; bit b;} vec_t;
  exp_t q[$], q3[$], e, e3;
  vec_t v[$];
  int checks = 0, passes = 0, n = 0;
  logic piv = 0, piv3 = 0;
  task automatic check(input string nm, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask
  always @(posedge clk) begin
    piv <= in_valid;
    piv3 <= in_valid3;
  end
  always @(negedge clk) begin
    if (piv || out_valid) check("out_valid_timing", int'(out_valid), int'(piv));
    if (out_valid) begin
      if (q.size() == 0) check("unexpected_output", 1, 0);
      else begin
        e = q.pop_front();
        check($sformatf("data[%0d]", e.n), int'(out_data), e.d);
        check($sformatf("active_sel[%0d]", e.n), int'(active_sel), e.a);
        check($sformatf("busy[%0d]", e.n), int'(busy), int'(e.b));
      end
    end
    if (piv3 || out_valid3) check("out_valid3_timing", int'(out_valid3), int'(piv3));
    if (out_valid3) begin
      if (q3.size() == 0) check("unexpected_output3", 1, 0);
      else begin
        e3 = q3.pop_front();
        check($sformatf("data3[%0d]", e3.n), int'(out_data3), e3.d);
        check($sformatf("active_sel3[%0d]", e3.n), int'(active_sel3), e3.a);
        check($sformatf("busy3[%0d]", e3.n), int'(busy3), int'(e3.b));
      end
    end
  end
  task automatic strobe(input logic [1:0] s, input int d, input int a, input bit b);
    src_data = {16'(1234), 16'(-800), 16'(-3), 16'(1000)};
    sel = s;
    q.push_back('{d, a, b, n});
    n++;
    @(posedge clk); #1 in_valid = 1;
    @(posedge clk); #1 in_valid = 0;
    @(posedge clk); #1;
  endtask
  task automatic strobe3(input logic [1:0] s, input int d, input int a, input bit b);
    src3_data = {16'(-800), 16'(500), 16'(1000)};
    sel3 = s;
    q3.push_back('{d, a, b, n});
    n++;
    @(posedge clk); #1 in_valid3 = 1;
    @(posedge clk); #1 in_valid3 = 0;
    @(posedge clk); #1;
  endtask
  initial begin
    v.push_back('{2'd0, 0, 0, 1});
    v.push_back('{2'd0, 250, 0, 1});
    v.push_back('{2'd0, 500, 0, 1});
    v.push_back('{2'd0, 750, 0, 1});
    v.push_back('{2'd0, 1000, 0, 0});
    v.push_back('{2'd0, 1000, 0, 0});
    v.push_back('{2'd2, 1000, 0, 1});
    v.push_back('{2'd2, 750, 0, 1});
    v.push_back('{2'd2, 500, 0, 1});
    v.push_back('{2'd2, 250, 0, 1});
    v.push_back('{2'd2, 0, 2, 1});
    v.push_back('{2'd2, -200, 2, 1});
    v.push_back('{2'd2, -400, 2, 1});
    v.push_back('{2'd2, -600, 2, 1});
    v.push_back('{2'd2, -800, 2, 0});
    v.push_back('{2'd0, -800, 2, 1});
    v.push_back('{2'd0, -600, 2, 1});
    v.push_back('{2'd2, -400, 2, 1});
    v.push_back('{2'd2, -600, 2, 1});
    v.push_back('{2'd2, -800, 2, 0});
    v.push_back('{2'd1, -800, 2, 1});
    v.push_back('{2'd1, -600, 2, 1});
    v.push_back('{2'd1, -400, 2, 1});
    v.push_back('{2'd1, -200, 2, 1});
    v.push_back('{2'd1, 0, 1, 1});
    v.push_back('{2'd1, -1, 1, 1});
    v.push_back('{2'd1, -2, 1, 1});
    v.push_back('{2'd1, -3, 1, 1});
    v.push_back('{2'd1, -3, 1, 0});
    #12;
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_active_sel", int'(active_sel), 0);
    check("rst_busy", int'(busy), 1);
    check("rst_busy3", int'(busy3), 1);
    @(posedge clk); #1 rst = 0;
    foreach (v[i]) strobe(v[i].sel, v[i].d, v[i].a, v[i].b);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1 sel = 2'($urandom_range(0, 3));
    end
    sel = 1;
    @(posedge clk); #1;
    check("idle_active_sel", int'(active_sel), 1);
    check("idle_busy", int'(busy), 0);
    check("idle_out_data", int'(out_data), -3);
    strobe(2'd1, -3, 1, 0);
    strobe(2'd0, -3, 1, 1);
    strobe(2'd0, -3, 1, 1);
    #2 rst = 1;
    #1;
    check("midfade_rst_out_data", int'(out_data), 0);
    check("midfade_rst_active_sel", int'(active_sel), 0);
    check("midfade_rst_busy", int'(busy), 1);
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1;
    check("post_rst_out_data", int'(out_data), 0);
    strobe(2'd0, 0, 0, 1);
    strobe(2'd0, 250, 0, 1);
    strobe3(2'd0, 0, 0, 1);
    strobe3(2'd0, 250, 0, 1);
    strobe3(2'd0, 500, 0, 1);
    strobe3(2'd0, 750, 0, 1);
    strobe3(2'd0, 1000, 0, 0);
    strobe3(2'd3, 1000, 0, 0);
    strobe3(2'd3, 1000, 0, 0);
    strobe3(2'd1, 1000, 0, 1);
    strobe3(2'd1, 750, 0, 1);
    repeat (4) @(posedge clk);
    #1;
    check("queue_drained", q.size(), 0);
    check("queue3_drained", q3.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
